// File: rtl/memcore_pkg.sv
// Shared definitions for the memcore BRAM read-side client:
// FSM state encoding and skid buffer depth.
package memcore_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/memcore_read_skid.sv
// Two-entry in-order data+last buffer with simultaneous push/pop.
// Entry 0 is always the head, so the output never needs a read mux.
module memcore_read_skid
  import memcore_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] data0, data1;
  logic                  last0, last1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ   <= '0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == '0) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          occ <= occ + 1'b1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          occ   <= occ - 1'b1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: the new word lands
          // behind whatever remains.
          if (occ == OCC_W'(1)) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = data0;
  assign head_last = last0;

  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && occ == OCC_W'(SKID_DEPTH)));

endmodule

// File: rtl/memcore_bram_stream_reader.sv
// Burst reader for the memcore read port: issues one read per cycle while
// the skid buffer has room and streams the words out with a last flag.
module memcore_bram_stream_reader
  import memcore_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int LEN_WIDTH     = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_address1,
  output logic                     mem_ce1,
  input  logic [DATA_WIDTH-1:0]    mem_q1,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  rd_state_t              state, state_nx;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]     remaining_q;
  logic                     inflight_q, inflight_last_q;
  logic [OCC_W-1:0]         occ;
  logic                     accept, pop, issue, issue_last;
  logic [2:0]               fill;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign out_valid  = (occ != '0);
  assign pop        = out_valid && out_ready;

  // A read may issue only if its word is guaranteed a slot when it lands,
  // counting the word already in flight and any beat leaving this cycle.
  assign fill       = {1'b0, occ} + {2'b00, inflight_q};
  assign issue      = (state == READ) && (fill < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (remaining_q == LEN_WIDTH'(1));

  assign mem_ce1      = issue;
  assign mem_address1 = addr_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (cmd_len != '0) ? READ : DRAIN;
      READ:    if (issue_last) state_nx = DRAIN;
      DRAIN:   if (!inflight_q && occ == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state           <= state_nx;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (accept) begin
        addr_q      <= cmd_addr;
        remaining_q <= cmd_len;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  // q1 is only meaningful the cycle after a ce1 edge, so capture is gated
  // purely by inflight.
  memcore_read_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(mem_q1),
    .push_last(inflight_last_q),
    .pop      (pop),
    .head_data(out_data),
    .head_last(out_last),
    .occ      (occ)
  );

endmodule

// File: tb/tb_memcore_bram_stream_reader.sv
// Directed bench for memcore_bram_stream_reader with a behavioural BRAM read port.
module tb_memcore_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  cmd_addr;
  logic [6:0]  cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  mem_address1;
  logic        mem_ce1;
  logic [31:0] mem_q1;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  always #5 clk = ~clk;

  memcore_bram_stream_reader #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(6), .LEN_WIDTH(7)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mem_address1(mem_address1), .mem_ce1(mem_ce1), .mem_q1(mem_q1),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // Memory with 1-cycle registered read; q1 holds stale data when ce1 is low.
  logic [31:0] ram [64];
  always @(posedge clk) if (mem_ce1) mem_q1 <= ram[mem_address1];

  int tests = 0;
  int fails = 0;

  logic [31:0] got_d [$];
  logic        got_l [$];
  logic [5:0]  got_a [$];
  int cyc, first_v, first_pop, last_pop, valid_n, busy_n, viol;
  int occ_m, infl_m;
  logic stall_prev;
  logic [31:0] held;
  logic busy_s, cmd_ready_s;

  typedef struct {
    logic [5:0]  addr;
    logic [6:0]  len;
    logic [15:0] pat;
    logic [31:0] first_d;
    logic [31:0] last_d;
    int          span;
    int          lat;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    got_d.delete(); got_l.delete(); got_a.delete();
    cyc = 0; first_v = -1; first_pop = -1; last_pop = -1;
    valid_n = 0; busy_n = 0; viol = 0;
  endtask

  // One clock cycle: drive ready at the falling edge, sample, update the
  // occupancy model, then return just after the rising edge.
  task automatic cycle(input logic rdy);
    logic pop;
    @(negedge clk);
    out_ready = rdy;
    #1;
    pop = out_valid && out_ready;
    if (out_valid !== (occ_m != 0)) viol++;
    if (mem_ce1 && (occ_m + infl_m >= 2 + int'(pop))) viol++;
    if (stall_prev && (!out_valid || out_data !== held)) viol++;
    if (busy && cmd_ready) viol++;
    if (out_valid) begin
      valid_n++;
      if (first_v < 0) first_v = cyc;
    end
    if (pop) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (mem_ce1) got_a.push_back(mem_address1);
    if (busy) busy_n++;
    busy_s      = busy;
    cmd_ready_s = cmd_ready;
    stall_prev  = out_valid && !out_ready;
    held        = out_data;
    occ_m       = occ_m + infl_m - int'(pop);
    infl_m      = int'(mem_ce1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [5:0] a, input logic [6:0] l, input logic [15:0] pat);
    bit ok;
    clear_stats();
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    cycle(pat[0]);
    chk("cmd_ready_at_accept", cmd_ready_s, 1);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 1; i < 300; i++) begin
      cycle(pat[4'(i % 16)]);
      if (!busy_s) begin ok = 1'b1; break; end
    end
    chk("burst_terminates", ok, 1);
    chk("cmd_ready_after_drain", cmd_ready_s, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit acc2;
    for (int i = 0; i < 64; i++) ram[i] = 32'h100 + i;
    vecs[0] = '{6'd0,  7'd8, 16'hFFFF, 32'h100, 32'h107, 7, 2};
    vecs[1] = '{6'd0,  7'd5, 16'hFFE9, 32'h100, 32'h104, -1, -1};
    vecs[2] = '{6'd62, 7'd4, 16'hFFFF, 32'h13E, 32'h101, 3, 2};
    vecs[3] = '{6'd0,  7'd0, 16'hFFFF, 32'h0,   32'h0,   -1, -1};
    vecs[4] = '{6'd5,  7'd3, 16'h5555, 32'h105, 32'h107, -1, -1};

    reset = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
    occ_m = 0; infl_m = 0; stall_prev = 1'b0; held = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_ce1", mem_ce1, 0);
    chk("rst_mem_address1", mem_address1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].pat);
      chk("beat_count", got_d.size(), vecs[v].len);
      chk("read_count", got_a.size(), vecs[v].len);
      for (int k = 0; k < got_d.size(); k++) begin
        chk("beat_data", got_d[k], 32'h100 + ((int'(vecs[v].addr) + k) & 63));
        chk("beat_last", got_l[k], (k == int'(vecs[v].len) - 1));
      end
      for (int k = 0; k < got_a.size(); k++)
        chk("read_addr", got_a[k], (int'(vecs[v].addr) + k) & 63);
      if (got_d.size() > 0) begin
        chk("first_beat", got_d[0], vecs[v].first_d);
        chk("final_beat", got_d[got_d.size()-1], vecs[v].last_d);
      end
      if (vecs[v].lat >= 0) chk("first_valid_latency", first_v - 1, vecs[v].lat);
      if (vecs[v].span >= 0) chk("beat_span", last_pop - first_pop, vecs[v].span);
      chk("issue_rule_stability", viol, 0);
      if (vecs[v].len == 0) begin
        chk("zero_len_busy_cycles", busy_n, 1);
        chk("zero_len_valid_cycles", valid_n, 0);
      end
    end

    // Asynchronous reset in the middle of a burst.
    clear_stats();
    cmd_addr = 6'd0; cmd_len = 7'd8; cmd_valid = 1'b1;
    cycle(1'b1);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1);
      if (got_d.size() == 3) begin ok = 1'b1; break; end
    end
    chk("mid_reset_third_beat", ok, 1);
    chk("mid_reset_pre_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_mem_ce1", mem_ce1, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_cmd_ready", cmd_ready, 1);
    chk("mid_reset_out_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    occ_m = 0; infl_m = 0; stall_prev = 1'b0;
    run_burst(6'd10, 7'd2, 16'hFFFF);
    chk("post_reset_count", got_d.size(), 2);
    chk("post_reset_beat0", got_d[0], 32'h10A);
    chk("post_reset_beat1", got_d[1], 32'h10B);
    chk("post_reset_last0", got_l[0], 0);
    chk("post_reset_last1", got_l[1], 1);
    chk("post_reset_rules", viol, 0);

    // Second command held valid during an active burst.
    clear_stats();
    cmd_addr = 6'd0; cmd_len = 7'd3; cmd_valid = 1'b1;
    cycle(1'b1);
    cmd_addr = 6'd20; cmd_len = 7'd1;
    acc2 = 1'b0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1);
      if (cmd_valid && cmd_ready_s) begin
        cmd_valid = 1'b0;
        acc2 = 1'b1;
        chk("second_cmd_after_first", got_d.size(), 3);
      end else if (acc2 && !busy_s && got_d.size() == 4) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("hold_terminates", ok, 1);
    chk("hold_count", got_d.size(), 4);
    chk("hold_beat0", got_d[0], 32'h100);
    chk("hold_beat2", got_d[2], 32'h102);
    chk("hold_last2", got_l[2], 1);
    chk("hold_beat3", got_d[3], 32'h114);
    chk("hold_last3", got_l[3], 1);
    chk("hold_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memcore_bram_stream_reader.md
Name: memcore_bram_stream_reader

Overview:
Read-side client for the simple dual-port BRAM memcore. It accepts a burst command (start address, length) and drives the memcore read port (address1/ce1/q1, 1-cycle registered read). It returns the words as a valid/ready stream with a last flag. A 2-entry skid buffer absorbs read latency under backpressure while sustaining 1 word/cycle. It sits between the memcore read port and downstream stream consumers (FIFO/burst readers).

Parameters:
DATA_WIDTH, 32, width of memory word and stream data
ADDRESS_WIDTH, 6, memcore address width; addresses wrap modulo 2^ADDRESS_WIDTH
LEN_WIDTH, 7, width of burst length field (max length 2^LEN_WIDTH-1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cmd_addr  input  ADDRESS_WIDTH  burst start address
cmd_len  input  LEN_WIDTH  number of words to read
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising edge
mem_address1  output  ADDRESS_WIDTH  to memcore address1
mem_ce1  output  1  to memcore ce1; high = issue one read
mem_q1  input  DATA_WIDTH  from memcore q1, valid the cycle after the ce1 edge
out_data  output  DATA_WIDTH  stream data
out_last  output  1  marks final word of burst
out_valid  output  1  stream valid
out_ready  input  1  stream ready; beat transfers on out_valid && out_ready
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, skid buffer empty, inflight=0, counters 0. Outputs: out_valid=0, out_last=0, out_data=0, mem_ce1=0, mem_address1=0, busy=0, cmd_ready=1. Reset mid-burst discards all buffered and in-flight words. Memory contents are untouched.
- FSM IDLE -> READ on command accept with cmd_len>0. Latch addr, remaining=cmd_len, last_pending=cmd_len.
- IDLE -> DRAIN on accept with cmd_len==0. DRAIN with an empty buffer returns to IDLE next edge. No reads and no beats occur; busy is high for exactly one cycle.
- READ -> DRAIN when the final read is issued (remaining reaches 0).
- DRAIN -> IDLE when inflight==0, buffer empty, and the last beat has been transferred.
- cmd_ready = (state==IDLE). Commands are never queued.
- Issue rule: mem_ce1 = (state==READ) && (occ + inflight - pop) < 2, where pop = out_valid && out_ready this cycle. This path is combinational from registered state and out_ready.
- mem_address1 = current address register. On issue: address increments by 1 with natural wrap, remaining decrements, inflight<=1; otherwise inflight<=0.
- Capture: when inflight==1, mem_q1 is written into the skid buffer at that edge. mem_q1 is never sampled otherwise, because q1 holds stale data when ce1 is low.
- Skid buffer: 2 entries, in-order. Push and pop can happen in the same cycle. Overflow is impossible by the issue rule; overflow is an assertion failure.
- out_valid = occ>0. out_data is the buffer head. out_last is high when the head word is the final word of the burst (tag stored per entry).
- Latency: command accepted at edge E0; first ce1 is in cycle E0->E1; data captured at E2; out_valid is high from E2. In steady state with out_ready=1, there is one beat per cycle and no bubbles.
- out_valid, once high, is held with out_data stable until the transfer.

Decomposition:
- Shared package memcore_pkg: FSM state encoding localparams (IDLE, READ, DRAIN) and a SKID_DEPTH=2 constant.
- One sub-module, memcore_read_skid: 2-entry data+last FIFO with occ output and simultaneous push/pop. The FSM, counters and issue logic stay in the top module.

Test Plan:
- Preload ram[i]=0x100+i (i=0..7). Send cmd addr=0 len=8 with out_ready=1. Required: beats 0x100..0x107 on 8 consecutive cycles, first out_valid 2 cycles after accept, out_last only on 0x107, cmd_ready=1 the cycle after DRAIN exits.
- Same preload, len=5, out_ready pattern 1,0,0,1,0,1,1,... Required: exactly 0x100..0x104 in order with no duplicates or drops. At every edge, ce1 never fires while occ+inflight-pop>=2. out_data is stable while stalled.
- ADDRESS_WIDTH=6, cmd addr=62 len=4. Required: mem_address1 sequence 62,63,0,1; data matches ram[62],ram[63],ram[0],ram[1].
- cmd len=0. Required: mem_ce1 never high, out_valid never high, busy high for 1 cycle, then cmd_ready=1.
- Burst addr=0 len=8; assert reset=0 after the third beat. Required: out_valid, mem_ce1 and busy go 0 immediately, without waiting for a clock edge. After release, cmd addr=10 len=2 yields only ram[10], ram[11] with out_last on the second beat.
- Hold cmd_valid with addr=20 len=1 during an active len=3 burst. Required: cmd_ready=0 until IDLE; the second command is accepted only afterward and yields ram[20] with out_last=1.
